// File: rtl/mod_soma_matriz_if.sv
// mod_soma_matriz_if: request/result bundle for the 5x5 matrix adder.
// Ports: start, tamanho, matriz_a, matriz_b (to slave);
//        resultado, ocupado, pronto, overflow, erro (from slave).
interface mod_soma_matriz_if;
    logic         start;
    logic [2:0]   tamanho;
    logic [199:0] matriz_a;
    logic [199:0] matriz_b;
    logic [199:0] resultado;
    logic         ocupado;
    logic         pronto;
    logic         overflow;
    logic         erro;

    modport master (
        output start, tamanho, matriz_a, matriz_b,
        input  resultado, ocupado, pronto, overflow, erro
    );

    modport slave (
        input  start, tamanho, matriz_a, matriz_b,
        output resultado, ocupado, pronto, overflow, erro
    );
endinterface

// File: rtl/mod_soma_matriz.sv
// mod_soma_matriz: sequential NxN (N=2..5) signed 8-bit matrix adder,
// one element per cycle, over 5x5 row-major buses (stride 5).
// Ports: clk, reset (sync, active-high), bus (slave modport):
//   start/tamanho/matriz_a/matriz_b in; resultado/ocupado/pronto/
//   overflow (sticky)/erro (illegal-size pulse) out.
module mod_soma_matriz (
    input  logic             clk,
    input  logic             reset,
    mod_soma_matriz_if.slave bus
);
    typedef enum logic [1:0] {OCIOSO, CALCULA, FIM} estado_t;

    estado_t      estado;
    estado_t      prox_estado;
    logic [199:0] reg_a;
    logic [199:0] reg_b;
    logic [199:0] soma_mat;
    logic [2:0]   n;
    logic [2:0]   lin;
    logic [2:0]   col;
    logic         ovf;
    logic         erro_q;
    logic         aceita;
    logic         recusa;
    logic         calcula;
    logic         ultimo;
    logic         tam_ok;
    logic [7:0]   pos;
    logic [7:0]   elem_a;
    logic [7:0]   elem_b;
    logic [7:0]   soma;
    logic         ovf_elem;

    assign tam_ok = (bus.tamanho >= 3'd2) && (bus.tamanho <= 3'd5);

    // Bit offset of (lin,col): 8*(5*lin+col), fixed stride of 5.
    assign pos = {5'd0, lin} * 8'd40 + {5'd0, col} * 8'd8;

    assign elem_a = reg_a[pos +: 8];
    assign elem_b = reg_b[pos +: 8];
    assign soma   = elem_a + elem_b;

    // Signed overflow: equal operand signs, different result sign.
    assign ovf_elem = (elem_a[7] == elem_b[7]) && (soma[7] != elem_a[7]);

    assign ultimo = (lin == n - 3'd1) && (col == n - 3'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        aceita      = 1'b0;
        recusa      = 1'b0;
        calcula     = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (bus.start) begin
                    if (tam_ok) begin
                        aceita      = 1'b1;
                        prox_estado = CALCULA;
                    end else begin
                        recusa = 1'b1;
                    end
                end
            end
            CALCULA: begin
                calcula = 1'b1;
                if (ultimo) begin
                    prox_estado = FIM;
                end
            end
            FIM: begin
                prox_estado = OCIOSO;
            end
            default: begin
                prox_estado = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_a    <= '0;
            reg_b    <= '0;
            soma_mat <= '0;
            n        <= '0;
            lin      <= '0;
            col      <= '0;
            ovf      <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            erro_q <= recusa;
            if (aceita) begin
                reg_a    <= bus.matriz_a;
                reg_b    <= bus.matriz_b;
                n        <= bus.tamanho;
                soma_mat <= '0;
                ovf      <= 1'b0;
                lin      <= '0;
                col      <= '0;
            end else if (calcula) begin
                soma_mat[pos +: 8] <= soma;
                if (ovf_elem) begin
                    ovf <= 1'b1;
                end
                if (col == n - 3'd1) begin
                    col <= '0;
                    lin <= lin + 3'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end
        end
    end

    assign bus.resultado = soma_mat;
    assign bus.overflow  = ovf;
    assign bus.erro      = erro_q;
    assign bus.ocupado   = (estado == CALCULA);
    assign bus.pronto    = (estado == FIM);
endmodule
